apb_master_bridge: RTL

- Upstream APB requester that turns a simple valid/ready command stream into APB3 transfers. It drives the 8-bit peripheral register slaves on the local APB segment.
- Generates the psel/penable/pwrite/paddr/pwdata sequence, honours pready wait states, and returns prdata/pslverr as a single-entry response.
- Adds a bounded wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/apb_master_bridge_pkg.sv | 23 ++
 rtl/apb_master_bridge_wait_timer.sv | 36 +++
 rtl/apb_master_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge and related APB masters.
//   - apb_state_e : bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   - *_DEF       : default address/data widths and wait-state timeout
//   - timer_width : counter width for a given timeout, never below 1 bit
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  // Width needed to count 0..timeout; a disabled timeout (0) still gets 1 bit.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_wait_timer.sv
// Wait-state counter shared by APB masters.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_clr     : clear counter to 0 (wins over i_en)
//   i_en      : increment counter by 1
//   i_limit   : compare value
//   o_expired : counter currently equals i_limit
module apb_wait_timer #(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: reset/clear to zero, otherwise count while enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == i_limit);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: converts a valid/ready command stream into APB transfers
// and returns a single-entry response, with an optional wait-state timeout.
//   pclk/preset             : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command channel (cmd_ready = IDLE)
//   rsp_valid/ready/rdata/err        : response channel (held until consumed)
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB3 bus
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int               CNT_W    = timer_width(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  // Abort fires on the ACCESS cycle where the count (0-based) hits TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LIMIT = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e        r_state, w_state_nxt;
  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_expired;
  logic w_timeout;

  // Clear on accept (entry to SETUP); count each stalled ACCESS cycle.
  assign w_tmr_clr = (r_state == IDLE) && cmd_valid;
  assign w_tmr_en  = (r_state == ACCESS) && !pready;
  assign w_timeout = TO_EN && w_tmr_expired;

  apb_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .i_clk     (pclk),
    .i_rst     (preset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .i_limit   (TO_LIMIT),
    .o_expired (w_tmr_expired)
  );

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          // Reads leave the previous write data on pwdata.
          w_pwdata_nxt  = cmd_write ? cmd_wdata : r_pwdata;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = SETUP;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end
      ACCESS: begin
        // A ready slave on the limit cycle completes normally.
        if (pready) begin
          w_rsp_err_nxt   = pslverr;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else if (w_timeout) begin
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else begin
          w_state_nxt     = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_state_nxt     = RESP;
        end
      end
      default: begin
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
